// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion stage: FSM state encoding,
// default constants and a width helper.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DIV,
        STORE
    } adc_state_e;

    localparam int unsigned ADC_DATA_W              = 16;
    localparam int unsigned ADC_OFFSET              = 5000;
    localparam int unsigned ADC_DIVISOR             = 144;
    localparam int unsigned ADC_SAMPLE_CYCLES_100MS = 5_000_000;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_scaler_if.sv
// Sample-in / result-out bundle between the ADC reader, adc_scaler and the
// display drivers. master drives samples, slave is the scaler.
interface adc_scaler_if
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W   = ADC_DATA_W,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned CH_COUNT = 2
) ();
    localparam int unsigned CH_W = clog2_min1(CH_COUNT);

    logic                      in_valid;
    logic [CH_W-1:0]           in_ch;
    logic [DATA_W-1:0]         in_data;
    logic                      raw_sel;
    logic [CH_COUNT*OUT_W-1:0] result;
    logic                      result_valid;
    logic [CH_W-1:0]           result_ch;
    logic                      frame_done;
    logic                      busy;

    modport master (
        output in_valid, in_ch, in_data, raw_sel,
        input  result, result_valid, result_ch, frame_done, busy
    );

    modport slave (
        input  in_valid, in_ch, in_data, raw_sel,
        output result, result_valid, result_ch, frame_done, busy
    );
endinterface

// File: rtl/udiv_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. done pulses W
// cycles after start with q valid; the first step runs on the start edge.
module udiv_iter
    import adc_pkg::*;
#(
    parameter int unsigned W = ADC_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic         done
);
    localparam int unsigned CW = clog2_min1(W);

    logic [W-1:0]  rem_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  src_rem, src_quo, diff, nxt_rem, nxt_quo;
    logic [W:0]    shifted;
    logic          ge;

    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? a : q;
        shifted = {src_rem, src_quo[W-1]};
        ge      = (shifted >= {1'b0, b});
        // remainder stays below b, so the low W bits of the difference are exact
        diff    = shifted[W-1:0] - b;
        nxt_rem = ge ? diff : shifted[W-1:0];
        nxt_quo = {src_quo[W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            q     <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= nxt_rem;
                q     <= nxt_quo;
                cnt_q <= CW'(W - 1);
            end else if (cnt_q != '0) begin
                rem_q <= nxt_rem;
                q     <= nxt_quo;
                cnt_q <= cnt_q - CW'(1);
                done  <= (cnt_q == CW'(1));
            end
        end
    end
endmodule

// File: rtl/adc_scaler.sv
// Multi-channel ADC scaler: per-frame snapshot, clamp, offset, divide, publish.
// Macro ADC_SCALER_SAT_EN saturates oversize quotients; otherwise they wrap.
module adc_scaler
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W        = ADC_DATA_W,
    parameter int unsigned OUT_W         = 8,
    parameter int unsigned CH_COUNT      = 2,
    parameter int unsigned SAMPLE_CYCLES = ADC_SAMPLE_CYCLES_100MS,
    parameter int unsigned OFFSET        = ADC_OFFSET,
    parameter int unsigned DIVISOR       = ADC_DIVISOR
) (
    input  logic         clk,
    input  logic         rst_n,
    adc_scaler_if.slave  bus
);
    localparam int unsigned CH_W  = clog2_min1(CH_COUNT);
    localparam int unsigned CNT_W = clog2_min1(SAMPLE_CYCLES);

    if (DIVISOR == 0) begin : g_div_zero
        $error("adc_scaler: DIVISOR must be nonzero");
    end
    if (OUT_W > DATA_W - 1) begin : g_out_w
        $error("adc_scaler: OUT_W must not exceed DATA_W-1");
    end

    adc_state_e                state;
    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick;
    logic [DATA_W-1:0]         latch  [CH_COUNT];
    logic [DATA_W-1:0]         shadow [CH_COUNT];
    logic [CH_W-1:0]           ch_q;
    logic                      raw_q;
    logic [OUT_W-1:0]          v_q;
    logic [CH_COUNT*OUT_W-1:0] result_q;
    logic                      rv_q, fd_q;
    logic [CH_W-1:0]           rch_q;
    logic [DATA_W-1:0]         x, dividend, quotient;
    logic [OUT_W-1:0]          div_v;
    logic                      div_start, div_done;

    assign tick = (tick_cnt == CNT_W'(SAMPLE_CYCLES - 1));

    always_comb begin
        x         = shadow[ch_q];
        div_start = (state == PREP) && !x[DATA_W-1] && !raw_q;
        dividend  = (x > DATA_W'(OFFSET)) ? x - DATA_W'(OFFSET) : '0;
`ifdef ADC_SCALER_SAT_EN
        div_v     = (quotient > DATA_W'((1 << OUT_W) - 1)) ? '1 : OUT_W'(quotient);
`else
        div_v     = OUT_W'(quotient);
`endif
    end

    udiv_iter #(.W(DATA_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .a     (dividend),
        .b     (DATA_W'(DIVISOR)),
        .q     (quotient),
        .done  (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CH_COUNT; k++) latch[k] <= '0;
        end else if (bus.in_valid) begin
            // out-of-range tags match no channel and are dropped
            for (int unsigned k = 0; k < CH_COUNT; k++) begin
                if (bus.in_ch == CH_W'(k)) latch[k] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ch_q     <= '0;
            raw_q    <= 1'b0;
            v_q      <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            fd_q     <= 1'b0;
            rch_q    <= '0;
            for (int unsigned k = 0; k < CH_COUNT; k++) shadow[k] <= '0;
        end else begin
            rv_q <= 1'b0;
            fd_q <= 1'b0;
            unique case (state)
                IDLE: if (tick) begin
                    shadow <= latch;
                    raw_q  <= bus.raw_sel;
                    ch_q   <= '0;
                    state  <= PREP;
                end
                PREP: begin
                    if (x[DATA_W-1]) begin
                        v_q   <= '0;
                        state <= STORE;
                    end else if (raw_q) begin
                        v_q   <= x[DATA_W-2 -: OUT_W];
                        state <= STORE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: if (div_done) begin
                    v_q   <= div_v;
                    state <= STORE;
                end
                STORE: begin
                    result_q[ch_q*OUT_W +: OUT_W] <= v_q;
                    rv_q  <= 1'b1;
                    rch_q <= ch_q;
                    if (ch_q == CH_W'(CH_COUNT - 1)) begin
                        fd_q  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ch_q  <= ch_q + CH_W'(1);
                        state <= PREP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.result_ch    = rch_q;
    assign bus.frame_done   = fd_q;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_adc_scaler.sv
// Directed bench for adc_scaler: three instances (default scaling, small
// divisor with three channels, minimum frame period).
module tb_adc_scaler;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0, errors = 0;
    int unsigned rv_cnt_a = 0, fd_cnt_c = 0;
    int unsigned rel;

`ifdef ADC_SCALER_SAT_EN
    localparam int unsigned SAT_EXP = 255;
`else
    localparam int unsigned SAT_EXP = 1;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_scaler_if #(.DATA_W(16), .OUT_W(8), .CH_COUNT(2)) if_a ();
    adc_scaler_if #(.DATA_W(16), .OUT_W(8), .CH_COUNT(3)) if_b ();
    adc_scaler_if #(.DATA_W(16), .OUT_W(8), .CH_COUNT(2)) if_c ();

    adc_scaler #(.CH_COUNT(2), .SAMPLE_CYCLES(100)) u_a (
        .clk(clk), .rst_n(rst_a), .bus(if_a));
    adc_scaler #(.CH_COUNT(3), .SAMPLE_CYCLES(100), .OFFSET(0), .DIVISOR(16)) u_b (
        .clk(clk), .rst_n(rst_b), .bus(if_b));
    adc_scaler #(.CH_COUNT(2), .SAMPLE_CYCLES(39)) u_c (
        .clk(clk), .rst_n(rst_c), .bus(if_c));

    always @(negedge clk) begin
        if (if_a.result_valid === 1'b1) rv_cnt_a++;
        if (if_c.frame_done === 1'b1) fd_cnt_c++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // returns at the negedge following posedge number n
    task automatic wait_cyc(input int unsigned n);
        if (cyc > n) begin
            errors++;
            $display("FAIL sched: at cycle %0d, wanted %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk);
    endtask

    task automatic write_a(input logic ch, input logic [15:0] d);
        if_a.in_valid = 1'b1; if_a.in_ch = ch; if_a.in_data = d;
        @(negedge clk);
        if_a.in_valid = 1'b0;
    endtask

    task automatic write_b(input logic [1:0] ch, input logic [15:0] d);
        if_b.in_valid = 1'b1; if_b.in_ch = ch; if_b.in_data = d;
        @(negedge clk);
        if_b.in_valid = 1'b0;
    endtask

    task automatic write_c(input logic ch, input logic [15:0] d);
        if_c.in_valid = 1'b1; if_c.in_ch = ch; if_c.in_data = d;
        @(negedge clk);
        if_c.in_valid = 1'b0;
    endtask

    initial begin
        if_a.in_valid = 1'b0; if_a.in_ch = '0; if_a.in_data = '0; if_a.raw_sel = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_ch = '0; if_b.in_data = '0; if_b.raw_sel = 1'b0;
        if_c.in_valid = 1'b0; if_c.in_ch = '0; if_c.in_data = '0; if_c.raw_sel = 1'b0;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result", if_a.result, 0);
        check("rst_busy", if_a.busy, 0);
        check("rst_rv", if_a.result_valid, 0);
        check("rst_fd", if_a.frame_done, 0);
        check("rst_ch", if_a.result_ch, 0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        rel = cyc;

        fork
            begin : seq_a
                int unsigned t, snap, rel2;
                write_a(1'b0, 16'd19400);
                write_a(1'b1, 16'd4000);
                t = rel + 100;
                wait_cyc(t + 17); check("a_rv_early", if_a.result_valid, 0);
                wait_cyc(t + 18);
                check("a_rv0", if_a.result_valid, 1);
                check("a_ch0", if_a.result_ch, 0);
                check("a_scaled0", if_a.result[7:0], 100);
                check("a_fd_mid", if_a.frame_done, 0);
                check("a_busy", if_a.busy, 1);
                wait_cyc(t + 36);
                check("a_rv1", if_a.result_valid, 1);
                check("a_ch1", if_a.result_ch, 1);
                check("a_scaled1", if_a.result[15:8], 0);
                check("a_fd", if_a.frame_done, 1);
                check("a_hold0", if_a.result[7:0], 100);
                wait_cyc(t + 37);
                check("a_idle", if_a.busy, 0);
                check("a_rv_end", if_a.result_valid, 0);

                write_a(1'b0, 16'h8000);
                write_a(1'b1, 16'h3F80);
                if_a.raw_sel = 1'b1;
                t = rel + 200;
                wait_cyc(t + 1); check("a_byp_early", if_a.result_valid, 0);
                wait_cyc(t + 2);
                check("a_neg_rv", if_a.result_valid, 1);
                check("a_neg", if_a.result[7:0], 0);
                wait_cyc(t + 4);
                check("a_raw_rv", if_a.result_valid, 1);
                check("a_raw", if_a.result[15:8], 8'h7F);
                check("a_raw_fd", if_a.frame_done, 1);
                wait_cyc(t + 5);
                if_a.raw_sel = 1'b0;
                write_a(1'b0, 16'd5144);
                write_a(1'b1, 16'd4000);

                t = rel + 300;
                wait_cyc(t + 5);
                write_a(1'b0, 16'd19400);
                wait_cyc(t + 18); check("a_mid_old", if_a.result[7:0], 1);
                wait_cyc(t + 36); check("a_mid_ch1", if_a.result[15:8], 0);
                t = rel + 400;
                wait_cyc(t + 18);
                check("a_mid_new_rv", if_a.result_valid, 1);
                check("a_mid_new", if_a.result[7:0], 100);

                t = rel + 500;
                wait_cyc(t + 5);
                snap = rv_cnt_a;
                rst_a = 1'b0;
                wait_cyc(t + 6);
                check("a_rst_busy", if_a.busy, 0);
                check("a_rst_result", if_a.result, 0);
                check("a_rst_rv", if_a.result_valid, 0);
                wait_cyc(t + 10);
                rst_a = 1'b1;
                rel2 = cyc;
                wait_cyc(rel2 + 60);
                check("a_rst_nopulse", rv_cnt_a, snap);
                check("a_rst_hold", if_a.result, 0);
                write_a(1'b0, 16'd19400);
                write_a(1'b1, 16'd4000);
                wait_cyc(rel2 + 117); check("a_clean_early", if_a.result_valid, 0);
                wait_cyc(rel2 + 118);
                check("a_clean_rv", if_a.result_valid, 1);
                check("a_clean_ch", if_a.result_ch, 0);
                check("a_clean", if_a.result[7:0], 100);
                wait_cyc(rel2 + 119);
                check("a_clean_cnt", rv_cnt_a, snap + 1);
            end
            begin : seq_b
                int unsigned t;
                write_b(2'd0, 16'd4112);
                write_b(2'd1, 16'd320);
                write_b(2'd3, 16'd800);
                write_b(2'd2, 16'd160);
                t = rel + 100;
                wait_cyc(t + 18);
                check("b_rv0", if_b.result_valid, 1);
                check("b_sat", if_b.result[7:0], SAT_EXP);
                wait_cyc(t + 54);
                check("b_fd", if_b.frame_done, 1);
                check("b_ch2", if_b.result_ch, 2);
                wait_cyc(t + 55);
                check("b_ch1_ign3", if_b.result[15:8], 20);
                check("b_ch2_val", if_b.result[23:16], 10);
                check("b_sat_hold", if_b.result[7:0], SAT_EXP);
                check("b_idle", if_b.busy, 0);
            end
            begin : seq_c
                write_c(1'b0, 16'd19400);
                write_c(1'b1, 16'd19400);
                wait_cyc(rel + 39 + 36);
                check("c_fd1", if_c.frame_done, 1);
                check("c_rv1", if_c.result_valid, 1);
                wait_cyc(rel + 425); check("c_fd_cnt9", fd_cnt_c, 9);
                wait_cyc(rel + 427);
                check("c_fd_cnt10", fd_cnt_c, 10);
                check("c_s0", if_c.result[7:0], 100);
                check("c_s1", if_c.result[15:8], 100);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/adc_scaler.md
# adc_scaler

Multi-channel successor to the single-channel ADS1115 conversion stage. It periodically snapshots the latest signed ADC word of each channel and processes each one in turn:
- clamps negative readings to zero,
- subtracts a fixed offset,
- divides by a fixed divisor on a shared iterative divider,
- publishes an OUT_W-bit scaled value per channel, or raw upper bits when raw mode is selected.

It sits between the ADC I2C reader and the display/LED drivers.

## Interface
- DATA_W, 16: ADC word width, two's complement.
- OUT_W, 8: result width per channel; OUT_W ≤ DATA_W-1.
- CH_COUNT, 2: number of channels, ≥1.
- SAMPLE_CYCLES, 5_000_000: frame period in clk cycles (100 ms at 50 MHz); ≥ CH_COUNT*(DATA_W+3)+1.
- OFFSET, 5000: unsigned value subtracted before division.
- DIVISOR, 144: unsigned, nonzero; 0 is an elaboration error.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_ch valid this cycle.
- in_ch  in  CH_W  channel tag, where CH_W = max(1,$clog2(CH_COUNT)).
- in_data  in  DATA_W  ADC conversion word.
- raw_sel  in  1  1: raw mode, 0: scaled mode; sampled at frame start.
- result  out  CH_COUNT*OUT_W  per-channel results; channel k occupies [k*OUT_W +: OUT_W].
- result_valid  out  1  one-cycle pulse when a channel slice is written.
- result_ch  out  CH_W  channel written in the result_valid cycle.
- frame_done  out  1  one-cycle pulse, coincident with result_valid of the last channel.
- busy  out  1  frame in progress (state ≠ IDLE).

## Operation
- Input latches:
  - in_valid with in_ch < CH_COUNT writes latch[in_ch].
  - in_ch ≥ CH_COUNT is ignored.
  - Latches are updated in any state.
- Tick counter: counts 0..SAMPLE_CYCLES-1 and wraps. The tick is the cycle where count == SAMPLE_CYCLES-1.
- FSM states IDLE, PREP, DIV, STORE:
  - **IDLE:** on tick, copy all latches to shadow registers, capture raw_sel, set ch=0, go to PREP. A tick outside IDLE is dropped; the frame is not restarted.
  - **PREP:** x = shadow[ch].
    - If x[DATA_W-1]=1: v=0, go to STORE.
    - Else if raw mode: v = x[DATA_W-2 -: OUT_W], go to STORE.
    - Else: dividend = (x > OFFSET) ? x-OFFSET : 0 (unsigned compare); assert div start; go to DIV.
  - **DIV:** wait for div_done, then v = quotient and go to STORE.
  - **STORE:** write the saturated/truncated v to the result slice ch; pulse result_valid; drive result_ch=ch.
    - If ch == CH_COUNT-1: pulse frame_done, go to IDLE.
    - Else: ch+1, go to PREP.
- Quotient is DATA_W wide; reduction to OUT_W is set by the macro under Configuration.
- An in_valid that arrives mid-frame affects only the next frame, because the shadow copy is taken at the tick.
- Reset values:
  - result=0, result_valid=0, frame_done=0, result_ch=0, busy=0.
  - Latches and shadows 0, counter 0, FSM in IDLE.
  - Asserting reset mid-frame aborts the frame; no further pulses are emitted for it.

## Timing
- Tick in cycle T gives PREP in T+1. In the scaled path, div start is in T+1 and div_done in T+1+DATA_W.
- STORE is in cycle T+2+DATA_W, so result_valid and the new slice are visible in T+3+DATA_W.
- Bypass path (negative input or raw mode): STORE in T+2, result_valid in T+3.
- Each further channel adds DATA_W+2 cycles (scaled) or 2 cycles (bypass).
- Worst-case frame length is CH_COUNT*(DATA_W+2)+1 cycles, which is less than SAMPLE_CYCLES.
- result holds its value between writes.

## Configuration
- ADC_SCALER_SAT_EN:
  - Defined: a quotient > 2^OUT_W-1 produces all-ones.
  - Undefined: the output is quotient[OUT_W-1:0] (wrap).
  - Raw and negative paths are unaffected either way.

## Structure
- Shared package adc_pkg:
  - FSM state enum (IDLE/PREP/DIV/STORE).
  - Default constants: ADC_DATA_W=16, ADC_OFFSET=5000, ADC_DIVISOR=144, ADC_SAMPLE_CYCLES_100MS=5_000_000.
- One sub-module, udiv_iter: unsigned restoring divider, one quotient bit per cycle, DATA_W cycles.
  - Ports: clk, rst_n, start, a, b, q, done.

## Test plan
Sim setup: SAMPLE_CYCLES=100, CH_COUNT=2; all other parameters at defaults unless stated.
- **Scaled value:** ch0=19400, ch1=4000 → ch0 slice=100 (14400/144), ch1 slice=0. result_valid at T+19 (ch0) and T+37 (ch1); frame_done with ch1.
- **Negative and raw:** ch0=0x8000 → slice 0 in bypass timing (T+3). With raw_sel=1 and ch1=0x3F80 → slice 0x7F.
- **Saturation:** OFFSET=0, DIVISOR=16, ch0=4112 (quotient 257) → 255 with ADC_SCALER_SAT_EN, 1 without.
- **Mid-frame input:** in_valid ch0=19400 during DIV of a frame snapshotting ch0=5144 → that frame gives 1, the next frame gives 100. in_ch=3 is ignored.
- **Reset mid-frame:** rst_n low during DIV → result=0, busy=0, no pulses. The next tick after release starts a clean frame.
- **Overlapping tick:** SAMPLE_CYCLES equal to the minimum legal value for two scaled channels → no dropped frames and exactly one frame_done per tick.
